// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM address and buffers up to two
// fetched instructions (with their PCs) for decode behind a valid/ready handshake.
`timescale 1ns/1ps
module fetch_unit #(
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    output logic [AW-1:0] rom_addr_o,
    input  logic [15:0]   rom_data_i,
    input  logic          br_valid_i,
    input  logic [AW-1:0] br_addr_i,
    output logic          instr_valid_o,
    output logic [15:0]   instr_o,
    output logic [AW-1:0] instr_pc_o,
    input  logic          instr_ready_i
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } q_state_t;

    q_state_t      state_r;
    logic          valid_r;
    logic [AW-1:0] pc_r;
    logic [15:0]   head_instr_r;
    logic [AW-1:0] head_pc_r;
    logic [15:0]   tail_instr_r;
    logic [AW-1:0] tail_pc_r;

    logic          pop_s;
    logic          push_s;
    logic [AW-1:0] br_target_s;
    logic [AW-1:0] pc_inc_s;

    assign br_target_s = {br_addr_i[AW-1:1], 1'b0};
    assign pc_inc_s    = pc_r + AW'(2);

    // Decode handshake and fetch qualification; a redirect suppresses the push.
    always_comb begin
        pop_s  = valid_r & instr_ready_i;
        push_s = 1'b0;
        if (br_valid_i) begin
            push_s = 1'b0;
        end else begin
            push_s = (state_r != FULL) | pop_s;
        end
    end

    // PC, occupancy and queue storage; the head entry register feeds decode directly.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r      <= EMPTY;
            valid_r      <= 1'b0;
            pc_r         <= RESET_PC;
            head_instr_r <= 16'h0000;
            head_pc_r    <= {AW{1'b0}};
            tail_instr_r <= 16'h0000;
            tail_pc_r    <= {AW{1'b0}};
        end else if (br_valid_i) begin
            pc_r    <= br_target_s;
            state_r <= EMPTY;
            valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                pc_r <= pc_inc_s;
            end
            case (state_r)
                EMPTY: begin
                    if (push_s) begin
                        head_instr_r <= rom_data_i;
                        head_pc_r    <= pc_r;
                        state_r      <= ONE;
                        valid_r      <= 1'b1;
                    end
                end
                ONE: begin
                    if (pop_s && push_s) begin
                        head_instr_r <= rom_data_i;
                        head_pc_r    <= pc_r;
                    end else if (push_s) begin
                        tail_instr_r <= rom_data_i;
                        tail_pc_r    <= pc_r;
                        state_r      <= FULL;
                    end else if (pop_s) begin
                        state_r <= EMPTY;
                        valid_r <= 1'b0;
                    end
                end
                FULL: begin
                    // Pop while full always refetches, so the tail refills in the same edge.
                    if (pop_s) begin
                        head_instr_r <= tail_instr_r;
                        head_pc_r    <= tail_pc_r;
                        tail_instr_r <= rom_data_i;
                        tail_pc_r    <= pc_r;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr_o    = pc_r;
    assign instr_valid_o = valid_r;
    assign instr_o       = head_instr_r;
    assign instr_pc_o    = head_pc_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a main instance (RESET_PC=0) and a wrap-around
// instance (RESET_PC=0xFFFC) share clock and reset; monitors check every decode pop.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;

    logic [15:0] rom_addr0, rom_data0, br_addr0, instr0, instr_pc0;
    logic        br_valid0 = 1'b0, instr_valid0, ready0 = 1'b0;

    logic [15:0] rom_addr1, rom_data1, instr1, instr_pc1;
    logic        instr_valid1, ready1 = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb0[$];
    logic [31:0] sb1[$];

    always #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] rom_f(input logic [15:0] a);
        case (a)
            16'h0000: rom_f = 16'h5CCD;
            16'h0002: rom_f = 16'h9200;
            16'h0004: rom_f = 16'h9A00;
            16'h0006: rom_f = 16'h8DAE;
            default:  rom_f = a ^ 16'hA5A5;
        endcase
    endfunction

    assign rom_data0 = rom_f(rom_addr0);
    assign rom_data1 = rom_f(rom_addr1);

    initial br_addr0 = 16'h0000;

    fetch_unit #(.AW(16), .RESET_PC(16'h0000)) dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .rom_addr_o(rom_addr0), .rom_data_i(rom_data0),
        .br_valid_i(br_valid0), .br_addr_i(br_addr0),
        .instr_valid_o(instr_valid0), .instr_o(instr0), .instr_pc_o(instr_pc0),
        .instr_ready_i(ready0)
    );

    fetch_unit #(.AW(16), .RESET_PC(16'hFFFC)) dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .rom_addr_o(rom_addr1), .rom_data_i(rom_data1),
        .br_valid_i(1'b0), .br_addr_i(16'h0000),
        .instr_valid_o(instr_valid1), .instr_o(instr1), .instr_pc_o(instr_pc1),
        .instr_ready_i(ready1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the main instance: every accepted head must match the scoreboard.
    always @(negedge sys_clk) begin
        if (!sys_rst && instr_valid0 && ready0) begin
            if (sb0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb0_unexpected: got {%04h,%04h} expected no pop", instr0, instr_pc0);
            end else begin
                check("sb0_head", {instr0, instr_pc0}, sb0.pop_front());
            end
        end
    end

    // Monitor for the wrap-around instance.
    always @(negedge sys_clk) begin
        if (!sys_rst && instr_valid1 && ready1) begin
            if (sb1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb1_unexpected: got {%04h,%04h} expected no pop", instr1, instr_pc1);
            end else begin
                check("sb1_head", {instr1, instr_pc1}, sb1.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Asserts reset between edges, checks the asynchronous reset state, releases after an edge.
    task automatic do_reset();
        #2;
        sys_rst = 1'b1;
        #1;
        check("rst_valid", {31'd0, instr_valid0}, 32'd0);
        check("rst_rom_addr", {16'd0, rom_addr0}, 32'h0000_0000);
        check("rst_instr", {16'd0, instr0}, 32'd0);
        check("rst_instr_pc", {16'd0, instr_pc0}, 32'd0);
        check("rst_rom_addr_wrap", {16'd0, rom_addr1}, 32'h0000_FFFC);
        step();
        sys_rst = 1'b0;
    endtask

    // Streams four instructions from both instances with ready held high.
    task automatic stream();
        logic [15:0] a1;
        logic [15:0] exp1;
        check("rel_valid", {31'd0, instr_valid0}, 32'd0);
        check("rel_rom_addr", {16'd0, rom_addr0}, 32'd0);
        sb0.push_back({16'h5CCD, 16'h0000});
        sb0.push_back({16'h9200, 16'h0002});
        sb0.push_back({16'h9A00, 16'h0004});
        sb0.push_back({16'h8DAE, 16'h0006});
        a1 = 16'hFFFC;
        for (int i = 0; i < 4; i++) begin
            sb1.push_back({rom_f(a1), a1});
            a1 = a1 + 16'd2;
        end
        ready0 = 1'b1;
        ready1 = 1'b1;
        exp1 = 16'hFFFC;
        for (int i = 0; i < 4; i++) begin
            step();
            exp1 = exp1 + 16'd2;
            check("stream_valid", {31'd0, instr_valid0}, 32'd1);
            check("stream_rom_addr", {16'd0, rom_addr0}, 32'(2 * (i + 1)));
            check("wrap_valid", {31'd0, instr_valid1}, 32'd1);
            check("wrap_rom_addr", {16'd0, rom_addr1}, {16'd0, exp1});
        end
        step();
        ready0 = 1'b0;
        ready1 = 1'b0;
        check("stream_drain", 32'(sb0.size()), 32'd0);
        check("wrap_drain", 32'(sb1.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        stream();

        // Back-pressure from reset: fill, hold, then drain in order.
        do_reset();
        step();
        check("bp_rom_addr1", {16'd0, rom_addr0}, 32'd2);
        step();
        check("bp_rom_addr2", {16'd0, rom_addr0}, 32'd4);
        step();
        check("bp_hold", {16'd0, rom_addr0}, 32'd4);
        check("bp_valid", {31'd0, instr_valid0}, 32'd1);
        sb0.push_back({16'h5CCD, 16'h0000});
        sb0.push_back({16'h9200, 16'h0002});
        sb0.push_back({16'h9A00, 16'h0004});
        ready0 = 1'b1;
        step();
        check("bp_pop_rom_addr", {16'd0, rom_addr0}, 32'd6);
        step();
        check("bp_pop_rom_addr2", {16'd0, rom_addr0}, 32'd8);
        step();
        ready0 = 1'b0;
        check("bp_drain", 32'(sb0.size()), 32'd0);

        // Redirect while full with a pop in the same cycle.
        step();
        check("full_hold", {16'd0, rom_addr0}, 32'h0000_000A);
        sb0.push_back({16'h8DAE, 16'h0006});
        ready0    = 1'b1;
        br_valid0 = 1'b1;
        br_addr0  = 16'h000B;
        step();
        br_valid0 = 1'b0;
        check("redir_valid", {31'd0, instr_valid0}, 32'd0);
        check("redir_rom_addr", {16'd0, rom_addr0}, 32'h0000_000A);
        sb0.push_back({rom_f(16'h000A), 16'h000A});
        step();
        check("redir_target_valid", {31'd0, instr_valid0}, 32'd1);
        step();
        ready0 = 1'b0;
        check("redir_drain", 32'(sb0.size()), 32'd0);

        // Back-to-back redirects: only the second target is fetched.
        step();
        br_valid0 = 1'b1;
        br_addr0  = 16'h0010;
        step();
        br_addr0 = 16'h0020;
        check("b2b_valid_first", {31'd0, instr_valid0}, 32'd0);
        step();
        br_valid0 = 1'b0;
        ready0    = 1'b1;
        check("b2b_valid_second", {31'd0, instr_valid0}, 32'd0);
        check("b2b_rom_addr", {16'd0, rom_addr0}, 32'h0000_0020);
        sb0.push_back({rom_f(16'h0020), 16'h0020});
        step();
        check("b2b_target_valid", {31'd0, instr_valid0}, 32'd1);
        step();
        ready0 = 1'b0;
        check("b2b_drain", 32'(sb0.size()), 32'd0);

        // Fill the queue, then reset asynchronously and restart streaming.
        step();
        step();
        check("pre_reset_full_valid", {31'd0, instr_valid0}, 32'd1);
        do_reset();
        stream();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
